// File: rtl/pc_reg.sv
// Free-running program counter for the fetch stage: steps by STEP each clock,
// async high-true clear to RESET_VALUE. Output comes straight from the register.
module pc_reg #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STEP        = 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst_n,   // high-true despite the name: 1 = reset
    output logic [WIDTH-1:0] pc_out
);

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Sum truncated to WIDTH bits: wraps modulo 2^WIDTH, carry dropped.
    always_comb begin
        pc_d = pc_q + STEP_W;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q <= RESET_W;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_reg.sv
// Directed bench for pc_reg: default instance (8-bit, +1, reset 0) and a
// WIDTH=4/STEP=2/RESET_VALUE=3 instance, checked with immediate assertions.
module tb_pc_reg;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] pc_a;
    logic [3:0] pc_b;

    int checks = 0;
    int errors = 0;

    pc_reg #(.WIDTH(8), .STEP(1), .RESET_VALUE(0)) dut_a (
        .clk    (clk),
        .rst_n  (rst_a),
        .pc_out (pc_a)
    );

    pc_reg #(.WIDTH(4), .STEP(2), .RESET_VALUE(3)) dut_b (
        .clk    (clk),
        .rst_n  (rst_b),
        .pc_out (pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] b_exp [8];
        b_exp = '{4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd1, 4'd3};

        // Reset held: both instances pinned at their reset values.
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        check("reset_init_a", pc_a, 8'h00);
        check("reset_init_b", {4'h0, pc_b}, 8'h03);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold_a[%0d]", i), pc_a, 8'h00);
        end
        check("reset_hold_b", {4'h0, pc_b}, 8'h03);

        // Release and count 1..10; also verify no change between edges.
        rst_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #2;
            check($sformatf("count_post[%0d]", i), pc_a, 8'(i));
            @(negedge clk);
            check($sformatf("count_neg[%0d]", i), pc_a, 8'(i));
        end

        // Mid-count reset: restart, reach 5, assert between edges.
        rst_a = 1'b1;
        #1;
        check("restart_clear", pc_a, 8'h00);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_reach5", pc_a, 8'h05);
        #2;
        rst_a = 1'b1;
        #1;
        check("mid_async_clear", pc_a, 8'h00);
        @(negedge clk);
        check("mid_hold", pc_a, 8'h00);
        rst_a = 1'b0;
        @(negedge clk);
        check("mid_restart", pc_a, 8'h01);

        // Short pulse sequence: 10 cycles reset, 1 cycle run, reset again.
        rst_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("pulse_pre[%0d]", i), pc_a, 8'h00);
        end
        rst_a = 1'b0;
        @(negedge clk);
        check("pulse_one", pc_a, 8'h01);
        rst_a = 1'b1;
        #1;
        check("pulse_clear", pc_a, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("pulse_post[%0d]", i), pc_a, 8'h00);
        end

        // Wrap-around: FF at 255, 00 at 256, 01 at 257.
        rst_a = 1'b0;
        for (int i = 1; i <= 257; i++) begin
            @(negedge clk);
            if (i == 255)      check("wrap_ff", pc_a, 8'hFF);
            else if (i == 256) check("wrap_00", pc_a, 8'h00);
            else if (i == 257) check("wrap_01", pc_a, 8'h01);
            else               check($sformatf("wrap_cnt[%0d]", i), pc_a, 8'(i));
        end

        // Parameterised instance: 3 -> 5,7,...,15,1,3 modulo 16.
        check("param_reset", {4'h0, pc_b}, 8'h03);
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("param_step[%0d]", i), {4'h0, pc_b}, {4'h0, b_exp[i]});
        end
        #2;
        rst_b = 1'b1;
        #1;
        check("param_async_clear", {4'h0, pc_b}, 8'h03);
        @(negedge clk);
        check("param_hold", {4'h0, pc_b}, 8'h03);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
Name: pc_reg

Overview:
- Program counter register for the simple RISC-V CPU fetch stage.
- Holds the current instruction address and advances it by a fixed step on every clock edge while out of reset.
- Its output drives the instruction-memory address, so only the low 8 bits are used (256-entry instruction ROM index).
- No branch or jump redirect in this block; it is a free-running, resettable address counter.

Parameters:
- WIDTH, 8, bit width of the program counter and of pc_out.
- STEP, 1, increment added per clock. Units are instruction-ROM entries, not bytes. Must be < 2^WIDTH.
- RESET_VALUE, 0, value loaded into the PC while reset is asserted. Must fit in WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge except reset.
- rst_n  input  1  asynchronous, active-high reset. The name is the codebase's standard reset port name; polarity is high-true for this block: 1 = reset asserted.
- pc_out  output  WIDTH  current program counter value, driven directly from the register (no combinational path from inputs).

Behaviour:
- Single WIDTH-bit register pc, with pc_out = pc.
- Reset assertion:
  - When rst_n goes 1, pc is forced to RESET_VALUE immediately (asynchronous), independent of clk.
  - pc is held at RESET_VALUE for as long as rst_n = 1; clock edges are ignored.
- Normal operation (rst_n = 0): on each rising edge of clk, pc <= pc + STEP.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH. Carry-out is discarded.
  - With defaults, 8'hFF increments to 8'h00 with no flag and no stall.
- Reset deassertion:
  - The first increment occurs on the first rising clk edge after rst_n falls to 0.
  - Deassertion coinciding with a clk edge: that edge is treated as still in reset; pc stays RESET_VALUE.
- Reset mid-count:
  - Asserting rst_n at any time returns pc_out to RESET_VALUE within the same time step. No partial or glitch value is registered.
  - Counting restarts from RESET_VALUE after release.
- Power-up: pc is undefined until the first reset assertion. Benches must apply reset before checking values.
- Latency: pc_out changes only on a rising clk edge (1 cycle per increment) or on reset assertion (combinational to the register's async clear/preset).
- No other outputs, enables or status signals.

Test Plan:
- Reset held: rst_n = 1 for 10 clock cycles -> pc_out = 0 throughout; clock edges have no effect.
- Release and count: rst_n 1 -> 0, run 10 cycles -> pc_out = 1, 2, ... 10 after edges 1..10. Value changes only at rising edges.
- Mid-count reset: after reaching pc_out = 5, raise rst_n between clock edges -> pc_out = 0 immediately, before the next edge. Hold 1 cycle, release -> 1 after the next edge.
- Short pulse sequence: rst_n = 1 for 10 cycles, 0 for exactly 1 cycle, then 1 again -> pc_out 0 -> 1 -> 0, and stays 0 for the following 10 cycles.
- Wrap-around: release reset, run 256 cycles with defaults -> pc_out reaches 8'hFF at cycle 255 and 8'h00 at cycle 256, then 8'h01.
- Parameter check: WIDTH = 4, STEP = 2, RESET_VALUE = 3 -> after reset 3, then 5, 7, 9, 11, 13, 15, 1 (mod 16).
